// File: rtl/vend_pkg.sv
// Shared types and constants for the vending order front-end.
package vend_pkg;

    localparam int MONEY_W = 4;
    localparam int TAG_W   = 2;
    localparam int COUNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_VEND,
        ST_REFUND
    } state_t;

    localparam logic [1:0] COIN_1  = 2'b00;
    localparam logic [1:0] COIN_2  = 2'b01;
    localparam logic [1:0] COIN_5  = 2'b10;
    localparam logic [1:0] COIN_10 = 2'b11;

    function automatic logic [MONEY_W-1:0] coin_value(input logic [1:0] code);
        logic [MONEY_W-1:0] v;
        case (code)
            COIN_1:  v = 4'd1;
            COIN_2:  v = 4'd2;
            COIN_5:  v = 4'd5;
            default: v = 4'd10;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_coin_adder.sv
// Coin decode plus credit add; flags a coin that would push credit past MAX_MONEY.
module vend_coin_adder
    import vend_pkg::*;
#(
    parameter int MAX_MONEY = 15
) (
    input  logic [MONEY_W-1:0] money_i,
    input  logic [1:0]         coin_code_i,
    output logic [MONEY_W-1:0] new_money_o,
    output logic               overflow_o
);

    localparam logic [MONEY_W:0] MAX_L = (MONEY_W+1)'(MAX_MONEY);

    logic [MONEY_W:0] sum_wide;

    // One extra bit so the ceiling compare sees the true sum.
    assign sum_wide    = {1'b0, money_i} + {1'b0, coin_value(coin_code_i)};
    assign overflow_o  = (sum_wide > MAX_L);
    assign new_money_o = sum_wide[MONEY_W-1:0];

endmodule

// File: rtl/vend_order_collector.sv
// Session FSM in front of the combinational Vending_Machine: credit, selection, vend and refund handoff.
// Optional idle auto-refund in COLLECT is enabled by defining VEND_TIMEOUT_EN.
module vend_order_collector
    import vend_pkg::*;
#(
    parameter int MAX_MONEY      = 15,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin_valid,
    input  logic [1:0]         coin_code,
    output logic               coin_reject,
    input  logic               sel_valid,
    input  logic [TAG_W-1:0]   sel_tag,
    input  logic [COUNT_W-1:0] sel_count,
    input  logic               cancel,
    output logic [TAG_W-1:0]   Tag,
    output logic [COUNT_W-1:0] count,
    output logic [MONEY_W-1:0] money,
    input  logic               possibility,
    input  logic [MONEY_W-1:0] remainingMoney,
    output logic               nack,
    output logic               vend_valid,
    input  logic               vend_ready,
    output logic [TAG_W-1:0]   vend_tag,
    output logic [COUNT_W-1:0] vend_count,
    output logic               refund_valid,
    input  logic               refund_ready,
    output logic [MONEY_W-1:0] refund_amount,
    output logic               busy
);

    state_t               state_q;
    logic                 coin_reject_q, nack_q, vend_valid_q, refund_valid_q, busy_q;
    logic [TAG_W-1:0]     tag_q, vend_tag_q;
    logic [COUNT_W-1:0]   count_q, vend_count_q;
    logic [MONEY_W-1:0]   money_q, change_q, refund_amount_q;
    logic [MONEY_W-1:0]   money_d;
    logic                 coin_ovf;
    logic                 timeout_hit;

    vend_coin_adder #(.MAX_MONEY(MAX_MONEY)) u_adder (
        .money_i     (money_q),
        .coin_code_i (coin_code),
        .new_money_o (money_d),
        .overflow_o  (coin_ovf)
    );

`ifdef VEND_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer_q;

    // Counts consecutive COLLECT cycles with neither a coin nor a selection.
    assign timeout_hit = (state_q == ST_COLLECT) && !coin_valid && !sel_valid &&
                         (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else if (state_q != ST_COLLECT || coin_valid || sel_valid) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            coin_reject_q   <= 1'b0;
            nack_q          <= 1'b0;
            vend_valid_q    <= 1'b0;
            refund_valid_q  <= 1'b0;
            busy_q          <= 1'b0;
            tag_q           <= '0;
            count_q         <= '0;
            money_q         <= '0;
            change_q        <= '0;
            vend_tag_q      <= '0;
            vend_count_q    <= '0;
            refund_amount_q <= '0;
        end else begin
            coin_reject_q <= 1'b0;
            nack_q        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (coin_valid) begin
                        if (coin_ovf) begin
                            coin_reject_q <= 1'b1;
                        end else begin
                            money_q <= money_d;
                            state_q <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (cancel || timeout_hit) begin
                        coin_reject_q   <= coin_valid;
                        refund_amount_q <= money_q;
                        refund_valid_q  <= 1'b1;
                        busy_q          <= 1'b1;
                        state_q         <= ST_REFUND;
                    end else begin
                        // Coin lands first so CHECK sees the summed credit.
                        if (coin_valid) begin
                            if (coin_ovf) coin_reject_q <= 1'b1;
                            else          money_q       <= money_d;
                        end
                        if (sel_valid && sel_count != '0) begin
                            tag_q   <= sel_tag;
                            count_q <= sel_count;
                            busy_q  <= 1'b1;
                            state_q <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    coin_reject_q <= coin_valid;
                    if (possibility) begin
                        vend_tag_q   <= tag_q;
                        vend_count_q <= count_q;
                        change_q     <= remainingMoney;
                        vend_valid_q <= 1'b1;
                        state_q      <= ST_VEND;
                    end else begin
                        nack_q  <= 1'b1;
                        tag_q   <= '0;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_COLLECT;
                    end
                end
                ST_VEND: begin
                    coin_reject_q <= coin_valid;
                    if (vend_ready) begin
                        vend_valid_q <= 1'b0;
                        money_q      <= '0;
                        tag_q        <= '0;
                        count_q      <= '0;
                        if (change_q != '0) begin
                            refund_amount_q <= change_q;
                            refund_valid_q  <= 1'b1;
                            state_q         <= ST_REFUND;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_REFUND: begin
                    coin_reject_q <= coin_valid;
                    if (refund_ready) begin
                        refund_valid_q  <= 1'b0;
                        refund_amount_q <= '0;
                        money_q         <= '0;
                        tag_q           <= '0;
                        count_q         <= '0;
                        busy_q          <= 1'b0;
                        state_q         <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign coin_reject   = coin_reject_q;
    assign nack          = nack_q;
    assign Tag           = tag_q;
    assign count         = count_q;
    assign money         = money_q;
    assign vend_valid    = vend_valid_q;
    assign vend_tag      = vend_tag_q;
    assign vend_count    = vend_count_q;
    assign refund_valid  = refund_valid_q;
    assign refund_amount = refund_amount_q;
    assign busy          = busy_q;

endmodule

// File: doc/vend_order_collector.md
Name: vend_order_collector

Overview:
- Upstream front-end stage for Vending_Machine. Accepts coins and a product selection, then drives the registered Tag/count/money inputs of Vending_Machine.
- Samples possibility/remainingMoney and hands off a dispense request followed by a change refund.
- Holds all session state: credit, selection and FSM. Vending_Machine stays purely combinational.

Parameters:
- MAX_MONEY, 15, credit ceiling (fits 4-bit money bus).
- TIMEOUT_CYCLES, 1000, idle cycles in COLLECT before auto-refund (used only with VEND_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- coin_valid  in  1  one-cycle coin insertion strobe.
- coin_code  in  2  00=1, 01=2, 10=5, 11=10 units.
- coin_reject  out  1  one-cycle pulse: coin refused.
- sel_valid  in  1  selection commit strobe.
- sel_tag  in  2  product tag.
- sel_count  in  3  quantity.
- cancel  in  1  user cancel strobe.
- Tag  out  2  to Vending_Machine.
- count  out  3  to Vending_Machine.
- money  out  4  to Vending_Machine, current credit.
- possibility  in  1  from Vending_Machine.
- remainingMoney  in  4  from Vending_Machine.
- nack  out  1  one-cycle pulse: order not possible.
- vend_valid  out  1  dispense request.
- vend_ready  in  1  dispenser accepts.
- vend_tag  out  2  held while vend_valid.
- vend_count  out  3  held while vend_valid.
- refund_valid  out  1  change/refund request.
- refund_ready  in  1  coin returner accepts.
- refund_amount  out  4  held while refund_valid.
- busy  out  1  high in CHECK, VEND, REFUND.

Behaviour:
- Reset (async, any state): state=IDLE. Tag, count, money, vend_tag, vend_count, refund_amount = 0. All valids and pulses = 0.
- States: IDLE, COLLECT, CHECK, VEND, REFUND. All outputs are registered.

Credit accumulation (IDLE/COLLECT):
- Coin accepted: money <= money + value, computed in 5 bits. IDLE moves to COLLECT.
- If money + value > MAX_MONEY: coin_reject pulses next cycle; money unchanged.
- Coins in CHECK/VEND/REFUND: coin_reject pulses; credit unchanged.

Selection and cancel:
- sel_valid in COLLECT with sel_count != 0: latch Tag/count; go to CHECK next cycle.
- sel_valid in IDLE, or with sel_count == 0: ignored.
- Same cycle coin + sel_valid in COLLECT: coin is added first, then selection is latched. CHECK sees the summed money.
- cancel in COLLECT: go to REFUND with refund_amount = money.
- cancel wins over a simultaneous sel_valid. Any simultaneous coin is still rejected.
- cancel in other states: ignored.

CHECK (exactly 1 cycle):
- Tag/count/money are stable; sample possibility and remainingMoney.
- possibility=1: latch vend_tag/vend_count and change = remainingMoney; go to VEND.
- possibility=0: nack pulses; Tag/count cleared; return to COLLECT with money kept.

VEND:
- vend_valid held with stable vend_tag/vend_count until vend_ready is sampled high.
- Then: change != 0 goes to REFUND with refund_amount = change; change == 0 goes to IDLE.
- money clears on handshake.

REFUND:
- refund_valid held until refund_ready; then IDLE with money = 0.
- Valid/ready latency: accepted on the cycle both are high; valid drops the next cycle.
- Reset asserted mid-VEND/REFUND abandons the transaction; no partial outputs persist.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- Defined: a counter runs in COLLECT and restarts on any coin or sel_valid. When it reaches TIMEOUT_CYCLES, go to REFUND with refund_amount = money, exactly as cancel does.
- Undefined: no counter; COLLECT waits indefinitely.

Decomposition:
- Package vend_pkg holds:
  - state enum (IDLE, COLLECT, CHECK, VEND, REFUND);
  - coin code constants and the coin value mapping (1/2/5/10);
  - MONEY_W=4, TAG_W=2, COUNT_W=3.
- One sub-module, vend_coin_adder: combinational decode plus saturating-check adder. Outputs new_money and overflow.

Test Plan:
- Coins 5,5 then sel tag=3,count=2; Vending_Machine returns possibility=1, remainingMoney=2 -> money=10, CHECK 1 cycle; vend_valid tag=3 count=2 until vend_ready; refund_valid amount=2; back to IDLE, money=0.
- Coins 10,5 then coin 1 -> third coin coin_reject pulse; money stays 15.
- money=2, sel with possibility=0 -> nack pulse; state COLLECT; money=2; add coin 5 and resel -> CHECK sees money=7.
- money=7, cancel and sel_valid same cycle -> REFUND amount=7; no vend_valid ever asserted.
- vend_ready held low 20 cycles -> vend_valid and vend_tag/count stable throughout; rst pulse mid-VEND -> all outputs 0 asynchronously, state IDLE.
- With VEND_TIMEOUT_EN and TIMEOUT_CYCLES=8: coin 2, then idle 8 cycles -> refund_valid amount=2. Without the macro: remains in COLLECT.
